// File: rtl/complex_add_subb_arb.sv
// complex_add_subb_arb: two-requester round-robin front end and two-stage
// pipeline around one shared complex add/subtract unit. Results return on a
// single registered response channel tagged with the requester index.

// Combinational complex add/subtract. Each component computes
// (subb_a ? -a : a) + (subb_b ? -b : b) mod 2^W. The carry is the carry-out of
// adding the two (possibly negated) W-bit terms.
module complex_add_subb #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_x,
   input  logic [W-1:0] a_y,
   input  logic [W-1:0] b_x,
   input  logic [W-1:0] b_y,
   input  logic         subb_a,
   input  logic         subb_b,
   output logic [W-1:0] s_x,
   output logic [W-1:0] s_y,
   output logic         c_x,
   output logic         c_y
);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] a_c [2];
   logic [W-1:0] b_c [2];
   logic [W-1:0] s_c [2];
   logic         c_c [2];

   assign a_c[0] = a_x;
   assign a_c[1] = a_y;
   assign b_c[0] = b_x;
   assign b_c[1] = b_y;

   // Component 0 is x, component 1 is y; both share the same subtract flags.
   for (genvar gi = 0; gi < 2; gi++) begin : g_comp
      logic [W-1:0] ta;
      logic [W-1:0] tb;
      // Two's-complement negate each term on demand, then add with carry-out.
      always_comb begin
         ta = subb_a ? (~a_c[gi] + ONE) : a_c[gi];
         tb = subb_b ? (~b_c[gi] + ONE) : b_c[gi];
         {c_c[gi], s_c[gi]} = {1'b0, ta} + {1'b0, tb};
      end
   end

   assign s_x = s_c[0];
   assign s_y = s_c[1];
   assign c_x = c_c[0];
   assign c_y = c_c[1];
endmodule

module complex_add_subb_arb #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [1:0]     req_subb_a,
   input  logic [1:0]     req_subb_b,
   input  logic [2*W-1:0] req_a_x,
   input  logic [2*W-1:0] req_a_y,
   input  logic [2*W-1:0] req_b_x,
   input  logic [2*W-1:0] req_b_y,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_s_x,
   output logic [W-1:0]   rsp_s_y,
   output logic           rsp_c_x,
   output logic           rsp_c_y,
   output logic           busy
);
   logic [W-1:0] a_x_of [2];
   logic [W-1:0] a_y_of [2];
   logic [W-1:0] b_x_of [2];
   logic [W-1:0] b_y_of [2];

   // Unpack the per-requester operand slices.
   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign a_x_of[gi] = req_a_x[gi*W +: W];
      assign a_y_of[gi] = req_a_y[gi*W +: W];
      assign b_x_of[gi] = req_b_x[gi*W +: W];
      assign b_y_of[gi] = req_b_y[gi*W +: W];
   end

   logic [1:0]   grant;
   logic [1:0]   ready_int;
   logic         last;
   logic         s2_free;
   logic         s1_adv;
   logic         accept;
   logic         sel;

   logic         s1_vld;
   logic         s1_id;
   logic         s1_subb_a;
   logic         s1_subb_b;
   logic [W-1:0] s1_a_x;
   logic [W-1:0] s1_a_y;
   logic [W-1:0] s1_b_x;
   logic [W-1:0] s1_b_y;

   logic [W-1:0] sum_x;
   logic [W-1:0] sum_y;
   logic         cry_x;
   logic         cry_y;

   // Round-robin grant: a lone requester wins; on contention ~last wins.
   always_comb begin
      grant = 2'b00;
      if (req_valid[0] && (!req_valid[1] || last)) grant[0] = 1'b1;
      if (req_valid[1] && (!req_valid[0] || !last)) grant[1] = 1'b1;
   end

   assign s2_free   = ~rsp_valid | rsp_ready;
   assign s1_adv    = s1_vld & s2_free;
   assign ready_int = grant & {2{~s1_vld | s2_free}};
   // rst_n only masks the visible ready; state is held by the async clear anyway.
   assign req_ready = ready_int & {2{rst_n}};
   assign accept    = |(req_valid & ready_int);
   assign sel       = ready_int[1];
   assign busy      = s1_vld | rsp_valid;

   // Priority pointer follows the most recently accepted requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (accept) begin
         last <= sel;
      end
   end

   // Stage 1: capture the accepted operand set; empties when it moves to S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s1_id     <= 1'b0;
         s1_subb_a <= 1'b0;
         s1_subb_b <= 1'b0;
         s1_a_x    <= '0;
         s1_a_y    <= '0;
         s1_b_x    <= '0;
         s1_b_y    <= '0;
      end else if (accept) begin
         s1_vld    <= 1'b1;
         s1_id     <= sel;
         s1_subb_a <= req_subb_a[sel];
         s1_subb_b <= req_subb_b[sel];
         s1_a_x    <= a_x_of[sel];
         s1_a_y    <= a_y_of[sel];
         s1_b_x    <= b_x_of[sel];
         s1_b_y    <= b_y_of[sel];
      end else if (s1_adv) begin
         s1_vld    <= 1'b0;
      end
   end

   complex_add_subb #(.W(W)) u_add (
      .a_x    (s1_a_x),
      .a_y    (s1_a_y),
      .b_x    (s1_b_x),
      .b_y    (s1_b_y),
      .subb_a (s1_subb_a),
      .subb_b (s1_subb_b),
      .s_x    (sum_x),
      .s_y    (sum_y),
      .c_x    (cry_x),
      .c_y    (cry_y)
   );

   // Stage 2: response register; loads whenever the consumer can take data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_s_x   <= '0;
         rsp_s_y   <= '0;
         rsp_c_x   <= 1'b0;
         rsp_c_y   <= 1'b0;
      end else if (s2_free) begin
         rsp_valid <= s1_vld;
         if (s1_vld) begin
            rsp_id  <= s1_id;
            rsp_s_x <= sum_x;
            rsp_s_y <= sum_y;
            rsp_c_x <= cry_x;
            rsp_c_y <= cry_y;
         end
      end
   end
endmodule

// File: tb/tb_complex_add_subb_arb.sv
// Directed and sweep bench for complex_add_subb_arb (W=4) with a scoreboard.
module tb_complex_add_subb_arb;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [1:0]     req_subb_a;
   logic [1:0]     req_subb_b;
   logic [2*W-1:0] req_a_x;
   logic [2*W-1:0] req_a_y;
   logic [2*W-1:0] req_b_x;
   logic [2*W-1:0] req_b_y;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [W-1:0]   rsp_s_x;
   logic [W-1:0]   rsp_s_y;
   logic           rsp_c_x;
   logic           rsp_c_y;
   logic           busy;

   complex_add_subb_arb #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_subb_a (req_subb_a),
      .req_subb_b (req_subb_b),
      .req_a_x    (req_a_x),
      .req_a_y    (req_a_y),
      .req_b_x    (req_b_x),
      .req_b_y    (req_b_y),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_s_x    (rsp_s_x),
      .rsp_s_y    (rsp_s_y),
      .rsp_c_x    (rsp_c_x),
      .rsp_c_y    (rsp_c_y),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int push_cnt = 0;
   int pop_cnt = 0;
   int warns = 0;
   bit carry_strict = 1'b1;
   logic [1:0] acc;

   typedef struct {
      logic         id;
      logic [W-1:0] sx;
      logic [W-1:0] sy;
      logic         cx;
      logic         cy;
   } exp_t;
   exp_t sb[$];
   exp_t e_mon;
   exp_t e_new;
   logic [4:0] rx;
   logic [4:0] ry;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: negate in integer arithmetic, carry is the sum reaching 16.
   function automatic logic [4:0] model(input int a, input int b, input bit sa, input bit sbb);
      int ta;
      int tb;
      int t;
      ta = sa  ? (16 - a) % 16 : a;
      tb = sbb ? (16 - b) % 16 : b;
      t  = ta + tb;
      return {t >= 16, 4'(t % 16)};
   endfunction

   // Scoreboard: in-flight operations are discarded by reset.
   always @(negedge rst_n) sb.delete();

   // Monitor: consume responses, then record newly accepted requests.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid && rsp_ready) begin
            $display("RSP id=%0d sx=%0h sy=%0h cx=%0d cy=%0d", rsp_id, rsp_s_x, rsp_s_y, rsp_c_x, rsp_c_y);
            if (sb.size() == 0) begin
               check("spurious_rsp", 32'd1, 32'd0);
            end else begin
               e_mon = sb.pop_front();
               pop_cnt++;
               check("rsp_id", 32'(rsp_id), 32'(e_mon.id));
               check("rsp_s_x", 32'(rsp_s_x), 32'(e_mon.sx));
               check("rsp_s_y", 32'(rsp_s_y), 32'(e_mon.sy));
               if (carry_strict) begin
                  check("rsp_c_x", 32'(rsp_c_x), 32'(e_mon.cx));
                  check("rsp_c_y", 32'(rsp_c_y), 32'(e_mon.cy));
               end else if (rsp_c_x !== e_mon.cx || rsp_c_y !== e_mon.cy) begin
                  warns++;
                  $display("WARN carry got=%0d%0d exp=%0d%0d", rsp_c_x, rsp_c_y, e_mon.cx, e_mon.cy);
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               rx = model(int'(req_a_x[i*W +: W]), int'(req_b_x[i*W +: W]), req_subb_a[i], req_subb_b[i]);
               ry = model(int'(req_a_y[i*W +: W]), int'(req_b_y[i*W +: W]), req_subb_a[i], req_subb_b[i]);
               e_new.id = 1'(i);
               e_new.sx = rx[3:0];
               e_new.cx = rx[4];
               e_new.sy = ry[3:0];
               e_new.cy = ry[4];
               sb.push_back(e_new);
               push_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit sa, input bit sbb,
                          input int ax, input int bx, input int ay, input int by);
      req_subb_a[i]    = sa;
      req_subb_b[i]    = sbb;
      req_a_x[i*W +: W] = 4'(ax);
      req_b_x[i*W +: W] = 4'(bx);
      req_a_y[i*W +: W] = 4'(ay);
      req_b_y[i*W +: W] = 4'(by);
   endtask

   // code[3:0]=a_x, code[7:4]=b_x, code[8]=subb_a, code[9]=subb_b; y random.
   task automatic new_op(input int i, input int code);
      set_req(i, code[8], code[9], code & 15, (code >> 4) & 15,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int accepts;
   int sweep;
   int n;
   logic         snap_id;
   logic [W-1:0] snap_sx;
   logic [W-1:0] snap_sy;

   initial begin
      rst_n      = 1'b0;
      rsp_ready  = 1'b1;
      req_valid  = 2'b00;
      req_subb_a = 2'b00;
      req_subb_b = 2'b00;
      req_a_x    = '0;
      req_a_y    = '0;
      req_b_x    = '0;
      req_b_y    = '0;

      // Reset values with both requesters valid.
      set_req(0, 1'b0, 1'b0, 3, 2, 5, 1);
      set_req(1, 1'b0, 1'b1, 3, 2, 7, 9);
      req_valid = 2'b11;
      repeat (3) tick();
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_s_x", 32'(rsp_s_x), 32'd0);
      check("rst_rsp_s_y", 32'(rsp_s_y), 32'd0);
      check("rst_rsp_c", 32'({rsp_c_x, rsp_c_y}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check("first_grant", 32'(req_ready), 32'b01);

      // Single add from requester 0, then subtract and wrap from requester 1.
      tick();
      req_valid = 2'b10;
      check("r1_ready", 32'(req_ready), 32'b10);
      check("lat_early", 32'(rsp_valid), 32'd0);
      tick();
      set_req(1, 1'b0, 1'b0, 3, 2, 7, 9);
      check("add_valid", 32'(rsp_valid), 32'd1);
      check("add_id", 32'(rsp_id), 32'd0);
      check("add_sx", 32'(rsp_s_x), 32'd5);
      check("add_sy", 32'(rsp_s_y), 32'd6);
      check("add_c", 32'({rsp_c_x, rsp_c_y}), 32'b00);
      tick();
      req_valid = 2'b00;
      check("sub_id", 32'(rsp_id), 32'd1);
      check("sub_sx", 32'(rsp_s_x), 32'd1);
      check("sub_sy", 32'(rsp_s_y), 32'd14);
      check("sub_c", 32'({rsp_c_x, rsp_c_y}), 32'b10);
      tick();
      check("wrap_id", 32'(rsp_id), 32'd1);
      check("wrap_sx", 32'(rsp_s_x), 32'd5);
      check("wrap_sy", 32'(rsp_s_y), 32'd0);
      check("wrap_c", 32'({rsp_c_x, rsp_c_y}), 32'b01);
      tick();
      check("idle_valid", 32'(rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Round robin: both valid for six accepts, one response per cycle.
      new_op(0, int'($urandom_range(0, 1023)));
      new_op(1, int'($urandom_range(0, 1023)));
      req_valid = 2'b11;
      accepts = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               accepts++;
               new_op(i, int'($urandom_range(0, 1023)));
            end
         end
         if (accepts >= 6) req_valid = 2'b00;
         if (k >= 1) begin
            check("rr_valid", 32'(rsp_valid), 32'd1);
            check("rr_id", 32'(rsp_id), 32'((k - 1) % 2));
         end
      end
      check("rr_accepts", 32'(accepts), 32'd6);
      repeat (2) tick();

      // Backpressure with both requesters valid.
      new_op(0, int'($urandom_range(0, 1023)));
      new_op(1, int'($urandom_range(0, 1023)));
      req_valid = 2'b11;
      repeat (2) begin
         tick();
         for (int i = 0; i < 2; i++) if (acc[i]) new_op(i, int'($urandom_range(0, 1023)));
      end
      rsp_ready = 1'b0;
      #1;
      snap_id = rsp_id;
      snap_sx = rsp_s_x;
      snap_sy = rsp_s_y;
      check("bp_ready0", 32'(req_ready), 32'd0);
      check("bp_inflight", 32'(sb.size()), 32'd2);
      repeat (3) begin
         tick();
         check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_stable", 32'({rsp_id, rsp_s_x, rsp_s_y}), 32'({snap_id, snap_sx, snap_sy}));
         check("bp_held", 32'(sb.size()), 32'd2);
      end
      rsp_ready = 1'b1;
      repeat (4) begin
         tick();
         for (int i = 0; i < 2; i++) if (acc[i]) new_op(i, int'($urandom_range(0, 1023)));
      end
      req_valid = 2'b00;
      repeat (3) tick();
      check("bp_drained", 32'(sb.size()), 32'd0);
      check("bp_busy", 32'(busy), 32'd0);

      // Reset mid-flight with S1 and S2 both full.
      new_op(0, int'($urandom_range(0, 1023)));
      new_op(1, int'($urandom_range(0, 1023)));
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      repeat (2) begin
         tick();
         for (int i = 0; i < 2; i++) if (acc[i]) new_op(i, int'($urandom_range(0, 1023)));
      end
      check("mf_full_valid", 32'(rsp_valid), 32'd1);
      check("mf_full_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mf_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mf_busy", 32'(busy), 32'd0);
      check("mf_req_ready", 32'(req_ready), 32'd0);
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         check("mf_no_stale", 32'(rsp_valid), 32'd0);
      end

      // Sweep every x operand/flag combination with random valid and ready.
      carry_strict = 1'b0;
      push_cnt = 0;
      pop_cnt = 0;
      sweep = 0;
      n = 0;
      while ((sweep < 1024 || req_valid != 2'b00 || sb.size() != 0) && n < 20000) begin
         tick();
         n++;
         for (int i = 0; i < 2; i++) if (acc[i]) req_valid[i] = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] && sweep < 1024 && $urandom_range(0, 3) != 0) begin
               new_op(i, sweep);
               sweep++;
               req_valid[i] = 1'b1;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      rsp_ready = 1'b1;
      check("soak_in_time", 32'(n < 20000), 32'd1);
      check("soak_count", 32'(pop_cnt), 32'(push_cnt));
      check("soak_all", 32'(pop_cnt), 32'd1024);
      tick();
      check("soak_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
